// File: rtl/epoch_alarm_timer.sv
// Epoch seconds counter driven by the one_hz divider output, with N_ALARM independent
// compare channels (one-shot or periodic), sticky match/overrun flags and a combined irq.

module epoch_alarm_chan #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic [WIDTH-1:0] next_time,
  input  logic             we,
  input  logic [WIDTH-1:0] wr_cmp,
  input  logic [WIDTH-1:0] wr_per,
  input  logic             clr,
  output logic [WIDTH-1:0] cmp,
  output logic             armed,
  output logic             flag,
  output logic             ovr
);
  logic [WIDTH-1:0] per;
  logic             hit;

  // Compare against the value o_time takes at this edge so the flag rises with zero latency.
  assign hit = upd & armed & (next_time == cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp   <= '0;
      per   <= '0;
      armed <= 1'b0;
      flag  <= 1'b0;
      ovr   <= 1'b0;
    end else if (we) begin
      cmp   <= wr_cmp;
      per   <= wr_per;
      armed <= 1'b1;
      flag  <= 1'b0;
      ovr   <= 1'b0;
    end else if (hit) begin
      // A coincident clear loses to the set; overrun looks at the pre-clear flag.
      flag <= 1'b1;
      if (flag) ovr <= 1'b1;
      if (per == '0) armed <= 1'b0;
      else           cmp   <= cmp + per;
    end else if (clr) begin
      flag <= 1'b0;
      ovr  <= 1'b0;
    end
  end
endmodule

module epoch_alarm_timer #(
  parameter int WIDTH   = 64,
  parameter int N_ALARM = 4,
  parameter int SEL_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               one_hz,
  input  logic               count_enable,
  input  logic               load_enable,
  input  logic [WIDTH-1:0]   i_time,
  output logic [WIDTH-1:0]   o_time,
  input  logic               alarm_we,
  input  logic [SEL_W-1:0]   alarm_sel,
  input  logic [WIDTH-1:0]   alarm_cmp,
  input  logic [WIDTH-1:0]   alarm_per,
  input  logic [N_ALARM-1:0] flag_clr,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [WIDTH-1:0]   rd_cmp,
  output logic [N_ALARM-1:0] alarm_armed,
  output logic [N_ALARM-1:0] alarm_flag,
  output logic [N_ALARM-1:0] alarm_ovr,
  output logic               irq
);
  logic                            one_hz_q;
  logic                            tick;
  logic                            upd;
  logic [WIDTH-1:0]                next_time;
  logic [N_ALARM-1:0]              we_vec;
  logic [N_ALARM-1:0][WIDTH-1:0]   cmp_q;

  assign tick = one_hz & ~one_hz_q;
  assign upd  = load_enable | (count_enable & tick);

  always_comb begin
    next_time = o_time;
    if (load_enable)               next_time = i_time;
    else if (count_enable && tick) next_time = o_time + WIDTH'(1);
  end

  // Edge register resets high so a one_hz already high out of reset is not a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      one_hz_q <= 1'b1;
      o_time   <= '0;
    end else begin
      one_hz_q <= one_hz;
      o_time   <= next_time;
    end
  end

  // Out-of-range selects decode to no channel, so such writes are dropped.
  for (genvar c = 0; c < N_ALARM; c++) begin : g_ch
    assign we_vec[c] = alarm_we & (alarm_sel == SEL_W'(c));

    epoch_alarm_chan #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .upd       (upd),
      .next_time (next_time),
      .we        (we_vec[c]),
      .wr_cmp    (alarm_cmp),
      .wr_per    (alarm_per),
      .clr       (flag_clr[c]),
      .cmp       (cmp_q[c]),
      .armed     (alarm_armed[c]),
      .flag      (alarm_flag[c]),
      .ovr       (alarm_ovr[c])
    );
  end

  always_comb begin
    rd_cmp = '0;
    for (int c = 0; c < N_ALARM; c++)
      if (rd_sel == SEL_W'(c)) rd_cmp = cmp_q[c];
  end

  assign irq = |alarm_flag;
endmodule
